// File: rtl/benes_pkg.sv
`default_nettype none
// ============================================================================
// Package : benes_pkg
// Shared constants, sequencer states and the benes8 select-word layout.
// Rev     : 1.0
// ============================================================================
package benes_pkg;

   localparam int N     = 32;
   localparam int B8    = 5;
   localparam int B4    = 3;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

   // Select word: bit 4 first column, bits 3:1 inner benes4, bit 0 last column.
   typedef struct packed {
      logic          sf;
      logic [B4-1:0] s4;
      logic          sl;
   } benes8_sel_t;

endpackage
`default_nettype wire

// File: rtl/benes_sel_table.sv
`default_nettype none
// ============================================================================
// Module : benes_sel_table
// DEPTH x W select register file, one write port, asynchronous read port.
// Rev    : 1.0
// ============================================================================
module benes_sel_table #(
   parameter int DEPTH = benes_pkg::DEPTH,
   parameter int W     = benes_pkg::B8,
   parameter int AW    = benes_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] w_entry [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] r_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_q <= '0;
         end else if (i_we && (i_waddr == AW'(gi))) begin
            r_q <= i_wdata;
         end
      end

      assign w_entry[gi] = r_q;
   end

   assign o_rdata = w_entry[i_raddr];

endmodule
`default_nettype wire

// File: rtl/benes8_perm_sequencer.sv
`default_nettype none
// ============================================================================
// Module : benes8_perm_sequencer
// Streams 8-lane vectors through an external benes8, one table select per vector.
// Rev    : 1.0
// ============================================================================
module benes8_perm_sequencer #(
   parameter int N     = benes_pkg::N,
   parameter int B8    = benes_pkg::B8,
   parameter int DEPTH = benes_pkg::DEPTH,
   parameter int AW    = benes_pkg::AW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cfg_we,
   input  logic [AW-1:0]  cfg_addr,
   input  logic [B8-1:0]  cfg_data,
   input  logic [AW-1:0]  cfg_len,
   input  logic           start,
   output logic           busy,
   output logic           done,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8*N-1:0] x_bus,
   output logic [8*N-1:0] net_x,
   output logic [B8-1:0]  net_sel,
   input  logic [8*N-1:0] net_y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [8*N-1:0] y_bus
);

   import benes_pkg::*;

   seq_state_t     r_state;
   seq_state_t     w_state_nxt;
   logic [AW-1:0]  r_ptr;
   logic [AW-1:0]  r_len_q;
   logic           r_busy;
   logic           r_done;
   logic           r_s1_valid;
   logic           r_out_valid;
   logic [8*N-1:0] r_net_x;
   logic [8*N-1:0] r_y_bus;
   logic [B8-1:0]  r_net_sel;
   logic [B8-1:0]  w_tbl_rdata;
   logic           w_tbl_we;
   logic           w_in_ready;
   logic           w_accept;
   logic           w_s1_adv;
   logic           w_drained;
   logic           w_start_frame;
   logic           w_finish;

   assign w_s1_adv  = r_s1_valid & (~r_out_valid | out_ready);
   assign w_accept  = in_valid & w_in_ready;
   assign w_drained = ~r_s1_valid & (~r_out_valid | out_ready);
   assign w_tbl_we  = cfg_we & (r_state == ST_IDLE);

   benes_sel_table #(
      .DEPTH (DEPTH),
      .W     (B8),
      .AW    (AW)
   ) u_sel_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_tbl_we),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_data),
      .i_raddr (r_ptr),
      .o_rdata (w_tbl_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_in_ready    = 1'b0;
      w_start_frame = 1'b0;
      w_finish      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt   = ST_RUN;
               w_start_frame = 1'b1;
            end
         end
         ST_RUN: begin
            w_in_ready = ~r_s1_valid | w_s1_adv;
            if (w_accept && (r_ptr == r_len_q)) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_drained) begin
               w_state_nxt = ST_IDLE;
               w_finish    = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The pointer stops on the last index so the DRAIN state never reads past len_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_len_q <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_start_frame) begin
            r_len_q <= cfg_len;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
         end else if (w_finish) begin
            r_busy <= 1'b0;
         end
         if (w_accept && (r_ptr != r_len_q)) begin
            r_ptr <= r_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_net_x     <= '0;
         r_net_sel   <= '0;
         r_out_valid <= 1'b0;
         r_y_bus     <= '0;
      end else begin
         if (w_accept) begin
            r_net_x    <= x_bus;
            r_net_sel  <= w_tbl_rdata;
            r_s1_valid <= 1'b1;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s1_adv) begin
            r_y_bus     <= net_y;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign in_ready  = w_in_ready;
   assign net_x     = r_net_x;
   assign net_sel   = r_net_sel;
   assign out_valid = r_out_valid;
   assign y_bus     = r_y_bus;

endmodule
`default_nettype wire

// File: tb/tb_benes8_perm_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_benes8_perm_sequencer
// Self-checking bench with a behavioural benes8 network and frame model.
// Rev    : 1.0
// ============================================================================
module tb_benes8_perm_sequencer;

   localparam int N     = 32;
   localparam int B8    = 5;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_we = 1'b0;
   logic [AW-1:0]  cfg_addr = '0;
   logic [B8-1:0]  cfg_data = '0;
   logic [AW-1:0]  cfg_len = '0;
   logic           start = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b1;
   logic [8*N-1:0] x_bus = '0;
   logic [8*N-1:0] net_y;
   logic           busy, done, in_ready, out_valid;
   logic [8*N-1:0] net_x, y_bus;
   logic [B8-1:0]  net_sel;

   bit             loopback = 1'b1;
   int             total = 0;
   int             bad = 0;
   logic [B8-1:0]  m_tbl [DEPTH];
   logic [8*N-1:0] vecs [16];

   int             k_stall_from = -1, k_stall_len = 0, k_cfg_cycle = -1, k_rst_cycle = -1;
   logic [31:0]    k_start_mask = '0;
   logic [AW-1:0]  k_cfg_addr = '0;
   logic [B8-1:0]  k_cfg_data = '0;

   int             acc_c[$], out_c[$], done_c[$];
   logic [8*N-1:0] out_y[$], yb_h[$];
   logic [B8-1:0]  sel_after[$], sel_h[$];
   logic           busy_h[$], ir_h[$], ov_h[$];
   int             hold_breaks;

   benes8_perm_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_len(cfg_len), .start(start), .busy(busy), .done(done), .in_valid(in_valid),
      .in_ready(in_ready), .x_bus(x_bus), .net_x(net_x), .net_sel(net_sel), .net_y(net_y),
      .out_valid(out_valid), .out_ready(out_ready), .y_bus(y_bus)
   );

   always #5 clk = ~clk;

   // Behavioural benes4: column of 2x2 switches, two 2x2 middles, column of 2x2 switches.
   function automatic logic [4*N-1:0] benes4(input logic [4*N-1:0] x, input logic [2:0] s);
      logic [N-1:0] a[4], b[4], u[2], l[2];
      logic [4*N-1:0] r;
      for (int i = 0; i < 4; i++) a[i] = x[i*N +: N];
      for (int i = 0; i < 2; i++) begin
         b[2*i]   = s[2] ? a[2*i+1] : a[2*i];
         b[2*i+1] = s[2] ? a[2*i]   : a[2*i+1];
      end
      u[0] = s[1] ? b[2] : b[0];
      u[1] = s[1] ? b[0] : b[2];
      l[0] = s[1] ? b[3] : b[1];
      l[1] = s[1] ? b[1] : b[3];
      for (int i = 0; i < 2; i++) begin
         r[(2*i)*N +: N]   = s[0] ? l[i] : u[i];
         r[(2*i+1)*N +: N] = s[0] ? u[i] : l[i];
      end
      return r;
   endfunction

   function automatic logic [8*N-1:0] benes8(input logic [8*N-1:0] x, input logic [4:0] s);
      logic [N-1:0] a[8], b[8];
      logic [4*N-1:0] up, lo;
      logic [8*N-1:0] r;
      for (int i = 0; i < 8; i++) a[i] = x[i*N +: N];
      for (int i = 0; i < 4; i++) begin
         b[2*i]   = s[4] ? a[2*i+1] : a[2*i];
         b[2*i+1] = s[4] ? a[2*i]   : a[2*i+1];
      end
      for (int i = 0; i < 4; i++) begin
         up[i*N +: N] = b[2*i];
         lo[i*N +: N] = b[2*i+1];
      end
      up = benes4(up, s[3:1]);
      lo = benes4(lo, s[3:1]);
      for (int i = 0; i < 4; i++) begin
         r[(2*i)*N +: N]   = s[0] ? lo[i*N +: N] : up[i*N +: N];
         r[(2*i+1)*N +: N] = s[0] ? up[i*N +: N] : lo[i*N +: N];
      end
      return r;
   endfunction

   assign net_y = loopback ? net_x : benes8(net_x, net_sel);

   function automatic logic [8*N-1:0] exp_y(input int k);
      return loopback ? vecs[k] : benes8(vecs[k], m_tbl[k]);
   endfunction

   task automatic rand_vecs(input int n);
      for (int v = 0; v < n; v++)
         for (int k = 0; k < 8; k++) vecs[v][k*N +: N] = $urandom;
   endtask

   task automatic cfg_write(input logic [AW-1:0] a, input logic [B8-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      m_tbl[a] = d;
   endtask

   task automatic start_frame(input logic [AW-1:0] len, input bit we,
                              input logic [AW-1:0] a, input logic [B8-1:0] d);
      cfg_len = len; start = 1'b1; cfg_we = we; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      if (we) m_tbl[a] = d;
   endtask

   // Runs one frame cycle by cycle under the current knobs and records what was observed.
   task automatic drive_frame(input int nvec);
      int idx, stop_c;
      bit sel_pend, prev_hold, acc_now;
      logic [8*N-1:0] prev_y;
      acc_c.delete(); out_c.delete(); done_c.delete(); out_y.delete(); yb_h.delete();
      sel_after.delete(); sel_h.delete(); busy_h.delete(); ir_h.delete(); ov_h.delete();
      idx = 0; stop_c = -1; sel_pend = 0; prev_hold = 0; prev_y = '0; hold_breaks = 0;
      in_valid = (nvec > 0); x_bus = vecs[0];
      for (int c = 0; c < 200; c++) begin
         out_ready = !(c >= k_stall_from && c < k_stall_from + k_stall_len);
         start     = (c < 32) ? k_start_mask[c] : 1'b0;
         cfg_we    = (c == k_cfg_cycle); cfg_addr = k_cfg_addr; cfg_data = k_cfg_data;
         rst_n     = (c != k_rst_cycle);
         @(negedge clk);
         busy_h.push_back(busy); ir_h.push_back(in_ready); ov_h.push_back(out_valid);
         sel_h.push_back(net_sel); yb_h.push_back(y_bus);
         if (sel_pend) sel_after.push_back(net_sel);
         acc_now  = in_valid && in_ready;
         sel_pend = acc_now;
         if (acc_now) acc_c.push_back(c);
         if (out_valid && out_ready) begin out_c.push_back(c); out_y.push_back(y_bus); end
         if (done) done_c.push_back(c);
         if (prev_hold && (y_bus !== prev_y)) hold_breaks++;
         prev_hold = out_valid && !out_ready; prev_y = y_bus;
         if (stop_c < 0 && done) stop_c = c + 3;
         if (stop_c < 0 && c == k_rst_cycle) stop_c = c + 6;
         @(posedge clk); #1;
         if (acc_now && c != k_rst_cycle) begin
            idx++;
            in_valid = (idx < nvec);
            x_bus = vecs[idx];
         end
         if (c == stop_c) break;
      end
      in_valid = 0; start = 0; cfg_we = 0; out_ready = 1; rst_n = 1;
      k_stall_from = -1; k_stall_len = 0; k_cfg_cycle = -1; k_rst_cycle = -1; k_start_mask = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
      total++; if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL reset_hs got=%b want=00", {in_ready, out_valid}); end
      total++; if (net_sel !== '0) begin bad++; $display("FAIL reset_net_sel got=%h want=0", net_sel); end
      total++; if (net_x !== '0 || y_bus !== '0) begin bad++; $display("FAIL reset_data net_x/y_bus not zero"); end
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_seq_loopback();
      loopback = 1;
      cfg_write(0, 5'b10001); cfg_write(1, 5'b10101); cfg_write(2, 5'b11011); cfg_write(3, 5'b11111);
      for (int v = 0; v < 4; v++)
         for (int k = 0; k < 8; k++) vecs[v][k*N +: N] = N'(k << 19) | N'(v);
      start_frame(3, 0, '0, '0);
      drive_frame(4);
      total++; if (acc_c.size() != 4 || out_c.size() != 4) begin bad++; $display("FAIL seq_counts acc=%0d out=%0d want=4/4", acc_c.size(), out_c.size()); end
      for (int v = 0; v < 4 && v < acc_c.size() && v < out_c.size() && v < sel_after.size(); v++) begin
         total++; if (acc_c[v] != v) begin bad++; $display("FAIL seq_b2b v=%0d cyc=%0d want=%0d", v, acc_c[v], v); end
         total++; if (out_c[v] != acc_c[v] + 2) begin bad++; $display("FAIL seq_latency v=%0d out=%0d want=%0d", v, out_c[v], acc_c[v] + 2); end
         total++; if (out_y[v] !== exp_y(v)) begin bad++; $display("FAIL seq_data v=%0d got=%h want=%h", v, out_y[v], exp_y(v)); end
         total++; if (sel_after[v] !== m_tbl[v]) begin bad++; $display("FAIL seq_sel v=%0d got=%b want=%b", v, sel_after[v], m_tbl[v]); end
      end
      total++; if (done_c.size() != 1) begin bad++; $display("FAIL seq_done_count got=%0d want=1", done_c.size()); end
      if (done_c.size() == 1 && out_c.size() == 4) begin
         total++; if (done_c[0] != out_c[3] + 1) begin bad++; $display("FAIL seq_done_cyc got=%0d want=%0d", done_c[0], out_c[3] + 1); end
         total++; if ({busy_h[done_c[0]-1], busy_h[done_c[0]]} !== 2'b10) begin bad++; $display("FAIL seq_busy_fall got=%b want=10", {busy_h[done_c[0]-1], busy_h[done_c[0]]}); end
      end
   endtask

   task automatic test_identity_net();
      logic [8*N-1:0] want;
      loopback = 0;
      cfg_write(0, 5'b00000);
      for (int k = 0; k < 8; k++) begin vecs[0][k*N +: N] = N'(k); want[k*N +: N] = N'(k); end
      start_frame(0, 0, '0, '0);
      drive_frame(1);
      total++; if (out_y.size() != 1) begin bad++; $display("FAIL ident_count got=%0d want=1", out_y.size()); end
      else begin
         total++; if (out_y[0] !== want) begin bad++; $display("FAIL ident_data got=%h want=%h", out_y[0], want); end
      end
      total++; if (done_c.size() != 1) begin bad++; $display("FAIL ident_done got=%0d want=1", done_c.size()); end
   endtask

   task automatic test_random_net();
      int len;
      loopback = 0;
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < DEPTH; a++) cfg_write(AW'(a), B8'($urandom));
         len = $urandom_range(0, DEPTH - 1);
         rand_vecs(len + 1);
         start_frame(AW'(len), 0, '0, '0);
         drive_frame(len + 1);
         total++; if (out_y.size() != len + 1) begin bad++; $display("FAIL rand_count r=%0d got=%0d want=%0d", r, out_y.size(), len + 1); end
         for (int v = 0; v < out_y.size() && v <= len; v++) begin
            total++; if (out_y[v] !== exp_y(v)) begin bad++; $display("FAIL rand_data r=%0d v=%0d got=%h want=%h", r, v, out_y[v], exp_y(v)); end
         end
         total++; if (done_c.size() != 1) begin bad++; $display("FAIL rand_done r=%0d got=%0d want=1", r, done_c.size()); end
      end
   endtask

   task automatic test_backpressure();
      int early;
      loopback = 1;
      rand_vecs(4);
      start_frame(3, 0, '0, '0);
      k_stall_from = 1; k_stall_len = 5;
      drive_frame(4);
      early = 0;
      foreach (acc_c[i]) if (acc_c[i] < 6) early++;
      total++; if (early != 2) begin bad++; $display("FAIL bp_accepts_stalled got=%0d want=2", early); end
      total++; if (ir_h.size() > 2 && ir_h[2] !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", ir_h[2]); end
      total++; if (hold_breaks != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_breaks); end
      total++; if (out_y.size() != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", out_y.size()); end
      for (int v = 0; v < out_y.size() && v < 4; v++) begin
         total++; if (out_y[v] !== exp_y(v)) begin bad++; $display("FAIL bp_data v=%0d got=%h want=%h", v, out_y[v], exp_y(v)); end
      end
      total++; if (done_c.size() != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_c.size()); end
   endtask

   task automatic test_cfg_during_run();
      loopback = 1;
      cfg_write(2, 5'b00110);
      rand_vecs(4);
      k_cfg_cycle = 1; k_cfg_addr = 2; k_cfg_data = 5'b01010;
      start_frame(3, 0, '0, '0);
      drive_frame(4);
      total++; if (sel_after.size() < 3 || sel_after[2] !== 5'b00110) begin bad++; $display("FAIL cfgrun_a got=%b want=00110", sel_after.size() > 2 ? sel_after[2] : 5'bx); end
      start_frame(3, 0, '0, '0);
      drive_frame(4);
      total++; if (sel_after.size() < 3 || sel_after[2] !== 5'b00110) begin bad++; $display("FAIL cfgrun_b got=%b want=00110", sel_after.size() > 2 ? sel_after[2] : 5'bx); end
      start_frame(3, 1, 2, 5'b01010);
      drive_frame(4);
      total++; if (sel_after.size() < 3 || sel_after[2] !== 5'b01010) begin bad++; $display("FAIL cfgidle_c got=%b want=01010", sel_after.size() > 2 ? sel_after[2] : 5'bx); end
      total++; if (out_y.size() != 4 || done_c.size() != 1) begin bad++; $display("FAIL cfgidle_frame out=%0d done=%0d want=4/1", out_y.size(), done_c.size()); end
   endtask

   task automatic test_reset_midframe();
      loopback = 1;
      for (int a = 0; a < DEPTH; a++) cfg_write(AW'(a), B8'($urandom_range(1, 31)));
      rand_vecs(4);
      start_frame(3, 0, '0, '0);
      k_rst_cycle = 2;
      drive_frame(4);
      total++; if (ov_h[3] !== 1'b0 || busy_h[3] !== 1'b0) begin bad++; $display("FAIL rst_mid_ov_busy got=%b want=00", {ov_h[3], busy_h[3]}); end
      total++; if (ir_h[3] !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=0", ir_h[3]); end
      total++; if (sel_h[3] !== '0 || yb_h[3] !== '0) begin bad++; $display("FAIL rst_mid_regs sel=%b y=%h want=0", sel_h[3], yb_h[3]); end
      total++; if (done_c.size() != 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", done_c.size()); end
      for (int a = 0; a < DEPTH; a++) m_tbl[a] = '0;
      rand_vecs(8);
      start_frame(7, 0, '0, '0);
      drive_frame(8);
      total++; if (sel_after.size() != 8) begin bad++; $display("FAIL rst_tbl_count got=%0d want=8", sel_after.size()); end
      for (int v = 0; v < sel_after.size() && v < 8; v++) begin
         total++; if (sel_after[v] !== m_tbl[v]) begin bad++; $display("FAIL rst_tbl v=%0d got=%b want=%b", v, sel_after[v], m_tbl[v]); end
      end
   endtask

   task automatic test_wrap_and_start();
      loopback = 0;
      for (int a = 0; a < DEPTH; a++) cfg_write(AW'(a), B8'($urandom));
      rand_vecs(8);
      start_frame(7, 0, '0, '0);
      k_start_mask = (32'd1 << 3) | (32'd1 << 8) | (32'd1 << 9);
      drive_frame(8);
      total++; if (out_y.size() != 8) begin bad++; $display("FAIL wrap_count got=%0d want=8", out_y.size()); end
      for (int v = 0; v < out_y.size() && v < 8; v++) begin
         total++; if (out_y[v] !== exp_y(v)) begin bad++; $display("FAIL wrap_data v=%0d got=%h want=%h", v, out_y[v], exp_y(v)); end
      end
      total++; if (done_c.size() != 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", done_c.size()); end
      total++; if (busy_h[busy_h.size()-1] !== 1'b0) begin bad++; $display("FAIL wrap_restart busy=%b want=0", busy_h[busy_h.size()-1]); end
      rand_vecs(2);
      start_frame(1, 0, '0, '0);
      drive_frame(2);
      total++; if (sel_after.size() != 2) begin bad++; $display("FAIL wrap_next_count got=%0d want=2", sel_after.size()); end
      else begin
         total++; if (sel_after[0] !== m_tbl[0]) begin bad++; $display("FAIL wrap_ptr0 got=%b want=%b", sel_after[0], m_tbl[0]); end
         total++; if (sel_after[1] !== m_tbl[1]) begin bad++; $display("FAIL wrap_ptr1 got=%b want=%b", sel_after[1], m_tbl[1]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) vecs[i] = '0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_seq_loopback();
      test_identity_net();
      test_random_net();
      test_backpressure();
      test_cfg_during_run();
      test_reset_midframe();
      test_wrap_and_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/benes8_perm_sequencer.md
Name: benes8_perm_sequencer

Overview:
Sequencer and configurator for the 8-input Benes permutation network (benes8, 5-bit stage select: bit4 first column, bits3:1 inner benes4, bit0 last column).
- Holds a programmable table of select words.
- Accepts 8-lane input vectors through a valid/ready handshake and drives each vector into the network with the next table entry.
- Registers the permuted result behind an output valid/ready handshake.
- Sits between the feature-map reorder buffer and the CNN MAC array; the network itself is instantiated beside it, not inside it.

Parameters:
N, 32, lane width in bits
B8, 5, network select width
DEPTH, 8, select-table entries
AW, 3, table address width (log2 DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_data  in  B8  select word to write
cfg_len  in  AW  last table index used in a frame (frame = cfg_len+1 vectors)
start  in  1  begin a frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when frame fully drained
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted when valid&ready
x_bus  in  8*N  lanes 0..7, lane k at [k*N +: N]
net_x  out  8*N  registered lanes to network x0..x7
net_sel  out  B8  registered select to network s
net_y  in  8*N  network outputs y0..y7 (combinational path)
out_valid  out  1  result valid
out_ready  in  1  downstream accept
y_bus  out  8*N  registered permuted lanes

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; busy, done, in_ready, out_valid = 0; net_x, net_sel, y_bus = 0; ptr = 0; len_q = 0; all table entries = 0.
- Table: DEPTH x B8 registers. Write on cfg_we only in IDLE; writes while busy are ignored. Entries above cfg_len are not read.
- FSM:
  - IDLE: start=1 -> RUN, latch len_q=cfg_len, ptr=0, busy=1. If cfg_we and start occur in the same cycle, the write commits and is visible to the first vector.
  - RUN: in_ready = !s1_valid | s1_adv.
    - On accept: net_x<=x_bus, net_sel<=table[ptr], s1_valid<=1.
    - If ptr==len_q, go to DRAIN with ptr held; otherwise ptr<=ptr+1.
  - DRAIN: in_ready=0. When s1_valid=0 and out_valid=0 (or the final output is accepted that cycle), pulse done=1 for one cycle, busy<=0, then IDLE.
  - start in RUN/DRAIN is ignored.
- Pipeline (2 stages):
  - s1 = net_x/net_sel/s1_valid.
  - s2 = y_bus/out_valid.
  - s1_adv = s1_valid & (!out_valid | out_ready). On s1_adv, y_bus<=net_y and out_valid<=1. Otherwise out_valid clears on out_ready.
  - s1_valid clears when s1_adv and no new accept occurs.
- Latency: accept at cycle t -> out_valid at t+2 with no back-pressure; throughput 1 vector/cycle.
- Data is held stable while out_valid & !out_ready.
- net_sel holds its last value when idle (no glitching of the network).
- Back-pressure: out_ready=0 with both stages full -> in_ready=0; no data loss or duplication.
- Wrap-around: each frame restarts at ptr=0. cfg_len=0 -> frame of 1 vector using table[0]; cfg_len=DEPTH-1 uses all entries.
- Reset mid-frame: everything returns to reset values at the next edge; in-flight vectors are discarded and no done pulse is produced.

Decomposition:
- Package benes_pkg: lane width N, B8, B4, DEPTH/AW constants, FSM state enum (IDLE, RUN, DRAIN), select field positions (SF=4, S4=3:1, SL=0).
- One natural sub-module: benes_sel_table (DEPTH x B8 register file, one write port, one async read port, synchronous reset).
- FSM and pipeline stay in the top level.

Test Plan:
- Table 0:5'b10001, 1:5'b10101, 2:5'b11011, 3:5'b11111; cfg_len=3; start; 4 vectors with lane k = k<<19 back-to-back, out_ready=1, net_y looped from net_x -> net_sel sequence 10001,10101,11011,11111 on consecutive cycles; y_bus == inputs at t+2; done one cycle after the last output; busy falls with it.
- Real benes8 attached, table[0]=5'b00000, cfg_len=0, x lane k=k -> y_bus lanes equal 0..7 in order; done after 1 output.
- out_ready=0 for 5 cycles mid-frame, 4-entry frame -> in_ready drops after 2 accepts; y_bus stable; all 4 results emerge in order once released; no duplicates.
- cfg_we to addr 2 (data 5'b01010) during RUN -> ignored; next frame still uses the old table[2]; the same write in IDLE with start in the same cycle is used by vector 2.
- rst_n=0 for 1 cycle after 2 of 4 vectors accepted -> next cycle out_valid=0, busy=0, in_ready=0, net_sel=0, table all 0; no done pulse.
- start asserted during DRAIN and RUN -> no effect; cfg_len=7 frame of 8 vectors wraps ptr to 0 on the next frame.
